float_to_int_nb: RTL and testbench
==================================

Name: float_to_int_nb

Overview:
- Non-blocking, fully pipelined converter from IEEE 754 single-precision to a signed two's-complement integer.
- Sits directly downstream of the float adder/multiplier datapath in the DCT/quantisation chain.
- Turns float coefficients into fixed-width integers for the zig-zag/entropy stages.
- Accepts one operand per cycle, fixed latency, no back-pressure.

Parameters:
- OUT_W, 16, output integer width in bits (8..31), two's complement.
- ROUND, 0, rounding mode: 0 = round toward zero, 1 = round half away from zero.

Ports:
- clk  input  1  rising-edge clock
- nrst  input  1  asynchronous active-low reset
- din  input  32  single-precision operand {sign, exp[7:0], frac[22:0]}
- din_valid  input  1  din qualifier; sampled every rising edge
- dout  output  OUT_W  converted integer, two's complement
- dout_valid  output  1  dout qualifier
- dout_sat  output  1  result was clamped (overflow, Inf or NaN); qualified by dout_valid

Behaviour:
- Reset:
  - One clock (clk) and asynchronous active-low reset (nrst).
  - All valid and data pipeline registers clear asynchronously on nrst low.
  - dout = 0, dout_valid = 0, dout_sat = 0 while in reset.
  - Reset mid-stream discards every in-flight operand. No output appears for operands accepted before reset.
- Latency and throughput:
  - Fixed 3 cycles. din_valid high at edge N gives dout_valid high after edge N+3.
  - One operand per cycle. Bubbles propagate unchanged. No stall input.
  - Data registers load only when their stage valid is high. Data holds its last value otherwise.
- Stage 1 (unpack/classify), registered:
  - sign = din[31], e = din[30:23], m = {1, din[22:0]}.
  - zero class: e == 0, so denormals flush to 0. Also e < 126, or e == 126 with ROUND = 0.
  - special class: e == 255 (Inf or NaN).
  - big class: e >= 127 + OUT_W, magnitude >= 2^OUT_W.
  - Otherwise register m and shift amount sh = 150 - e (range 150-127-OUT_W+1 .. 24). Left shift is used when e > 150.
- Stage 2 (align), registered:
  - mag = integer part of m * 2^(e-150), width OUT_W+1 bits, unsigned.
  - rnd = first bit below the binary point, i.e. the 0.5 weight.
  - Bits below rnd are discarded. No sticky bit is needed for half-away-from-zero.
  - zero class forces mag = 0, rnd = 0.
- Stage 3 (round/saturate/negate), registered:
  - magr = mag + (ROUND ? rnd : 0), computed OUT_W+1 bits wide.
  - Positive operand: if magr > 2^(OUT_W-1)-1, or big/special class, then dout = 2^(OUT_W-1)-1 and dout_sat = 1.
  - Negative operand: if magr > 2^(OUT_W-1), or big/special class, then dout = -2^(OUT_W-1) and dout_sat = 1.
  - Exactly -2^(OUT_W-1) is representable: dout_sat = 0.
  - Otherwise dout = sign ? -magr : magr, dout_sat = 0.
  - NaN saturates according to its sign bit. Inf likewise.
  - Signed zero (0x80000000) yields dout = 0, dout_sat = 0, never a negative encoding.
- Consistency with the adder's truncation: with ROUND = 0, the conversion is exact truncation toward zero for all normal inputs.

Test Plan:
- Defaults (OUT_W=16, ROUND=0): din=0x40490FDB (3.14159) -> dout=0x0003 after exactly 3 cycles. din=0xC0200000 (-2.5) -> 0xFFFE. Both dout_sat=0.
- ROUND=1: 0xC0200000 -> 0xFFFD (-3). 0x3F000000 (0.5) -> 0x0001. 0x3EFFFFFF -> 0x0000. 0x3FBFFFFF (1.49999) -> 0x0001. All dout_sat=0.
- Saturation, OUT_W=16:
  - 0x47000000 (32768.0) -> 0x7FFF, sat=1.
  - 0xC7000000 (-32768.0) -> 0x8000, sat=0.
  - 0xC7000080 (-32768.5) -> 0x8000, sat=0 with ROUND=0, sat=1 with ROUND=1.
  - 0x4F000000 (2^31) -> 0x7FFF, sat=1.
- Specials: 0x7F800000 -> 0x7FFF sat=1. 0xFF800000 -> 0x8000 sat=1. 0x7FC00000 -> 0x7FFF sat=1. 0x00000001 (denormal) -> 0 sat=0. 0x80000000 -> 0 sat=0.
- Streaming: 64 random operands, back-to-back with random din_valid bubbles. dout_valid must reproduce the din_valid pattern delayed 3 cycles, and each dout must match a reference model (truncf/roundf then clamp).
- Reset: assert nrst low for 1 cycle while 3 operands are in flight. dout, dout_valid and dout_sat must go to 0 immediately. No stale dout_valid afterwards. The next accepted operand appears 3 cycles after its din_valid.

Source files
------------

// File: rtl/float_to_int_nb.sv
// rtl/float_to_int_nb.sv - pipelined IEEE-754 single to signed integer converter
module float_to_int_nb #(
    parameter int OUT_W = 16,
    parameter int ROUND = 0
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [31:0]      din,
    input  logic             din_valid,
    output logic [OUT_W-1:0] dout,
    output logic             dout_valid,
    output logic             dout_sat
);

    // Smallest biased exponent whose magnitude is already >= 2^OUT_W.
    localparam logic [7:0] BIG_E = 8'(127 + OUT_W);

    // Largest positive and negative magnitudes, OUT_W+1 bits wide.
    localparam logic [OUT_W:0] POS_LIM = {2'b00, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W:0] NEG_LIM = {2'b01, {(OUT_W-1){1'b0}}};

    // Clamp values driven onto dout.
    localparam logic [OUT_W-1:0] POS_CLAMP = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] NEG_CLAMP = {1'b1, {(OUT_W-1){1'b0}}};

    // ------------------------------------------------------------------
    // Stage 1: unpack and classify
    // ------------------------------------------------------------------
    logic [7:0]  exp_w;
    logic        zero1_d;
    logic        ovf1_d;
    logic [4:0]  sh1_d;

    logic        v1_q;
    logic        sign1_q;
    logic        zero1_q;
    logic        ovf1_q;
    logic [23:0] m1_q;
    logic [4:0]  sh1_q;

    assign exp_w = din[30:23];

    // Classify the exponent; the shift is kept modulo 32 because the
    // normal-path shift 150-e only spans 24-OUT_W .. 24, which stage 2
    // rebases to 0..31 by adding 7.
    always_comb begin
        zero1_d = 1'b0;
        ovf1_d  = 1'b0;
        sh1_d   = 5'd22 - exp_w[4:0];
        if ((exp_w < 8'd126) || ((exp_w == 8'd126) && (ROUND == 0))) begin
            zero1_d = 1'b1;
        end
        if ((exp_w == 8'd255) || (exp_w >= BIG_E)) begin
            ovf1_d = 1'b1;
        end
    end

    // Stage 1 registers; data loads only with a valid operand.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            v1_q    <= 1'b0;
            sign1_q <= 1'b0;
            zero1_q <= 1'b0;
            ovf1_q  <= 1'b0;
            m1_q    <= '0;
            sh1_q   <= '0;
        end else begin
            v1_q <= din_valid;
            if (din_valid) begin
                sign1_q <= din[31];
                zero1_q <= zero1_d;
                ovf1_q  <= ovf1_d;
                m1_q    <= {1'b1, din[22:0]};
                sh1_q   <= sh1_d;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: align the mantissa to an integer plus one half-weight bit
    // ------------------------------------------------------------------
    logic [4:0]       sa;
    logic [32:0]      m_ext;
    logic [OUT_W+1:0] aligned;
    logic [OUT_W:0]   mag2_d;
    logic             rnd2_d;

    logic             v2_q;
    logic             sign2_q;
    logic             ovf2_q;
    logic [OUT_W:0]   mag2_q;
    logic             rnd2_q;

    // m_ext holds m*2^8, so shifting right by sh+7 leaves m*2^(1-sh):
    // the integer part in the upper bits and the 0.5 weight in bit 0.
    // Everything that survives the cast is below 2^(OUT_W+1) on the
    // normal path; larger operands were already classed as big.
    assign sa      = sh1_q + 5'd7;
    assign m_ext   = {1'b0, m1_q, 8'b0};
    assign aligned = (OUT_W+2)'(m_ext >> sa);

    // Zero-class operands contribute neither magnitude nor rounding.
    always_comb begin
        mag2_d = aligned[OUT_W+1:1];
        rnd2_d = aligned[0];
        if (zero1_q) begin
            mag2_d = '0;
            rnd2_d = 1'b0;
        end
    end

    // Stage 2 registers; data loads only when stage 1 holds a valid operand.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            v2_q    <= 1'b0;
            sign2_q <= 1'b0;
            ovf2_q  <= 1'b0;
            mag2_q  <= '0;
            rnd2_q  <= 1'b0;
        end else begin
            v2_q <= v1_q;
            if (v1_q) begin
                sign2_q <= sign1_q;
                ovf2_q  <= ovf1_q;
                mag2_q  <= mag2_d;
                rnd2_q  <= rnd2_d;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: round, saturate, negate
    // ------------------------------------------------------------------
    logic [OUT_W:0]   magr;
    logic [OUT_W:0]   neg_magr;
    logic [OUT_W-1:0] dout_d;
    logic             sat_d;

    logic [OUT_W-1:0] dout_q;
    logic             dout_valid_q;
    logic             dout_sat_q;

    // mag < 2^OUT_W, so adding the half bit cannot overflow OUT_W+1 bits.
    assign magr     = mag2_q + {{OUT_W{1'b0}}, (ROUND != 0) & rnd2_q};
    assign neg_magr = '0 - magr;

    // Clamp by sign; -2^(OUT_W-1) itself is representable and not clamped.
    always_comb begin
        dout_d = magr[OUT_W-1:0];
        sat_d  = 1'b0;
        if (sign2_q) begin
            if (ovf2_q || (magr > NEG_LIM)) begin
                dout_d = NEG_CLAMP;
                sat_d  = 1'b1;
            end else begin
                dout_d = neg_magr[OUT_W-1:0];
            end
        end else begin
            if (ovf2_q || (magr > POS_LIM)) begin
                dout_d = POS_CLAMP;
                sat_d  = 1'b1;
            end
        end
    end

    // Output registers; result loads only when stage 2 holds a valid operand.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            dout_valid_q <= 1'b0;
            dout_q       <= '0;
            dout_sat_q   <= 1'b0;
        end else begin
            dout_valid_q <= v2_q;
            if (v2_q) begin
                dout_q     <= dout_d;
                dout_sat_q <= sat_d;
            end
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign dout_sat   = dout_sat_q;

endmodule

// File: tb/tb_float_to_int_nb.sv
// tb/tb_float_to_int_nb.sv - scoreboard bench for float_to_int_nb, truncate and round builds
module tb_float_to_int_nb;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic [31:0] din = '0;
    logic        din_valid = 1'b0;

    logic [15:0] dout0, dout1;
    logic        dv0, dv1, ds0, ds1;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] d;
        bit          s;
        int          due;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    float_to_int_nb #(.OUT_W(16), .ROUND(0)) u_trunc (
        .clk(clk), .nrst(nrst), .din(din), .din_valid(din_valid),
        .dout(dout0), .dout_valid(dv0), .dout_sat(ds0)
    );

    float_to_int_nb #(.OUT_W(16), .ROUND(1)) u_round (
        .clk(clk), .nrst(nrst), .din(din), .din_valid(din_valid),
        .dout(dout1), .dout_valid(dv1), .dout_sat(ds1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, expv, cyc);
        end
    endtask

    // Reference: exact real value of the float, then truncf / roundf, then clamp.
    function automatic void model(input logic [31:0] f, input bit rnd,
                                  output logic [15:0] q, output bit s);
        int  e;
        real a;
        int  vi;
        e = int'(f[30:23]);
        s = 1'b0;
        if (e == 255) begin
            s = 1'b1;
            q = f[31] ? 16'h8000 : 16'h7FFF;
            return;
        end
        if (e == 0) begin
            a = 0.0;
        end else begin
            a = real'({1'b1, f[22:0]});
            if (e >= 150) repeat (e - 150) a = a * 2.0;
            else          repeat (150 - e) a = a / 2.0;
        end
        a = rnd ? $floor(a + 0.5) : $floor(a);
        if (!f[31] && a > 32767.0) begin
            q = 16'h7FFF;
            s = 1'b1;
        end else if (f[31] && a > 32768.0) begin
            q = 16'h8000;
            s = 1'b1;
        end else begin
            vi = $rtoi(a);
            if (f[31]) vi = -vi;
            q = vi[15:0];
        end
    endfunction

    task automatic send(input logic [31:0] f, input logic [15:0] e0, input bit s0,
                        input logic [15:0] e1, input bit s1);
        exp_t x;
        @(posedge clk);
        #1;
        din       = f;
        din_valid = 1'b1;
        x.due = cyc + 3;
        x.d = e0; x.s = s0; q0.push_back(x);
        x.d = e1; x.s = s1; q1.push_back(x);
    endtask

    task automatic send_model(input logic [31:0] f);
        logic [15:0] e0, e1;
        bit          s0, s1;
        model(f, 1'b0, e0, s0);
        model(f, 1'b1, e1, s1);
        send(f, e0, s0, e1, s1);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        din       = $urandom;
    endtask

    function automatic logic [31:0] rand_float();
        int sel;
        int e;
        sel = $urandom_range(0, 9);
        if (sel < 7)       e = $urandom_range(118, 160);
        else if (sel == 7) e = 255;
        else if (sel == 8) e = 0;
        else               e = $urandom_range(0, 254);
        return {1'($urandom_range(0, 1)), 8'(e), 23'($urandom)};
    endfunction

    // Monitor: every valid output must match the head of its queue on the due cycle.
    always @(negedge clk) begin
        exp_t x;
        if (dv0) begin
            if (q0.size() == 0) begin
                checks++; errors++;
                $display("FAIL trunc stray dout_valid: got 1 expected 0 at cycle %0d", cyc);
            end else begin
                x = q0.pop_front();
                chk("trunc latency", cyc, x.due);
                chk("trunc dout", {16'h0, dout0}, {16'h0, x.d});
                chk("trunc sat", {31'h0, ds0}, {31'h0, x.s});
            end
        end else if (q0.size() != 0 && q0[0].due <= cyc) begin
            x = q0.pop_front();
            chk("trunc missing dout_valid", {31'h0, dv0}, 32'h1);
        end
        if (dv1) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL round stray dout_valid: got 1 expected 0 at cycle %0d", cyc);
            end else begin
                x = q1.pop_front();
                chk("round latency", cyc, x.due);
                chk("round dout", {16'h0, dout1}, {16'h0, x.d});
                chk("round sat", {31'h0, ds1}, {31'h0, x.s});
            end
        end else if (q1.size() != 0 && q1[0].due <= cyc) begin
            x = q1.pop_front();
            chk("round missing dout_valid", {31'h0, dv1}, 32'h1);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset dout", {16'h0, dout0}, 32'h0);
        chk("reset dout_valid", {31'h0, dv0}, 32'h0);
        chk("reset dout_sat", {31'h0, ds0}, 32'h0);
        @(posedge clk);
        #3;
        nrst = 1'b1;

        // Directed vectors: {din, trunc result, sat, round result, sat}
        send(32'h40490FDB, 16'h0003, 0, 16'h0003, 0);
        send(32'hC0200000, 16'hFFFE, 0, 16'hFFFD, 0);
        send(32'h3F000000, 16'h0000, 0, 16'h0001, 0);
        send(32'h3EFFFFFF, 16'h0000, 0, 16'h0000, 0);
        send(32'h3FBFFFFF, 16'h0001, 0, 16'h0001, 0);
        idle();
        send(32'h47000000, 16'h7FFF, 1, 16'h7FFF, 1);
        send(32'hC7000000, 16'h8000, 0, 16'h8000, 0);
        send(32'hC7000080, 16'h8000, 0, 16'h8000, 1);
        send(32'h4F000000, 16'h7FFF, 1, 16'h7FFF, 1);
        send(32'h46FFFE00, 16'h7FFF, 0, 16'h7FFF, 0);
        send(32'h46FFFF00, 16'h7FFF, 0, 16'h7FFF, 1);
        idle();
        idle();
        send(32'h7F800000, 16'h7FFF, 1, 16'h7FFF, 1);
        send(32'hFF800000, 16'h8000, 1, 16'h8000, 1);
        send(32'h7FC00000, 16'h7FFF, 1, 16'h7FFF, 1);
        send(32'h00000001, 16'h0000, 0, 16'h0000, 0);
        send(32'h80000000, 16'h0000, 0, 16'h0000, 0);

        // Random stream with bubbles
        for (int i = 0; i < 64; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 2)) idle();
            end
            send_model(rand_float());
        end
        repeat (6) idle();

        // Reset with operands in flight
        send_model(rand_float());
        send_model(rand_float());
        send_model(32'h42F6E979);
        #2;
        nrst      = 1'b0;
        din_valid = 1'b0;
        q0.delete();
        q1.delete();
        #1;
        chk("mid-reset trunc dout", {16'h0, dout0}, 32'h0);
        chk("mid-reset trunc dout_valid", {31'h0, dv0}, 32'h0);
        chk("mid-reset trunc dout_sat", {31'h0, ds0}, 32'h0);
        chk("mid-reset round dout", {16'h0, dout1}, 32'h0);
        chk("mid-reset round dout_valid", {31'h0, dv1}, 32'h0);
        chk("mid-reset round dout_sat", {31'h0, ds1}, 32'h0);
        @(posedge clk);
        #3;
        nrst = 1'b1;
        repeat (5) idle();
        send(32'hC2C80000, 16'hFF9C, 0, 16'hFF9C, 0);
        repeat (8) idle();

        chk("trunc queue drained", q0.size(), 32'h0);
        chk("round queue drained", q1.size(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
